seg_scan_ctrl: RTL and testbench



---
 rtl/seg_scan_ctrl.sv | 103 ++++++++++
 tb/tb_seg_scan_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller: double-buffered BCD value,
// round-robin digit slots that each open with a blanking interval.
module seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000,
  parameter int BLANK  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  input  logic                blank_lz,
  output logic [3:0]          number,
  output logic [DIGITS-1:0]   an,
  output logic                pending,
  output logic                frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t              state, state_next;
  logic [CW-1:0]       cnt, cnt_next;
  logic [IW-1:0]       idx, idx_next;
  logic [4*DIGITS-1:0] shadow, active;
  logic                blz_q;
  logic                slot_end, frame_end;
  logic [3:0]          nib;
  logic                valid, suppress, zero_run;

  always_comb begin
    slot_end   = (cnt == CW'(DIV - 1));
    frame_end  = slot_end && (idx == IW'(DIGITS - 1));
    cnt_next   = slot_end ? '0 : cnt + 1'b1;
    idx_next   = idx;
    if (slot_end) begin
      idx_next = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
    state_next = state;
    case (state)
      ST_BLANK: if (!slot_end && cnt_next == CW'(BLANK)) state_next = ST_SHOW;
      ST_SHOW:  if (slot_end) state_next = ST_BLANK;
      default:  state_next = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
    end
  end

  // A load landing exactly on the frame end bypasses the shadow so it is not
  // left pending for a whole extra frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
      blz_q   <= 1'b0;
    end else begin
      blz_q <= blank_lz;
      if (load) begin
        shadow <= value;
      end
      if (load && frame_end) begin
        active  <= value;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end else if (frame_end && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
    end
  end

  // number is driven through BLANK too, so the decoder has settled before the
  // anode turns on; blank_lz is registered to keep inputs off the output paths.
  always_comb begin
    nib      = active[4*idx +: 4];
    valid    = (nib <= 4'd9);
    zero_run = 1'b1;
    suppress = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (active[4*k +: 4] == 4'd0);
      if (zero_run && idx == IW'(k)) suppress = blz_q;
    end
    number = valid ? nib : 4'd0;
    an     = '1;
    if (state == ST_SHOW && valid && !suppress) an[idx] = 1'b0;
    frame_done = frame_end;
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: cycle model feeding a scoreboard queue, a table of
// display vectors, and directed reset/load/race sequences.
module tb_seg_scan_ctrl;

  localparam int D = 4;
  localparam int V = 8;
  localparam int B = 2;
  localparam int F = D * V;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] number;
    logic       pending;
    logic       frame_done;
  } exp_t;

  typedef struct packed {
    logic [15:0] value;
    logic        blz;
    logic [15:0] exp_num;
    logic [3:0]  exp_dark;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic        blank_lz;
  logic [15:0] value;
  logic [3:0]  number;
  logic [3:0]  an;
  logic        pending;
  logic        frame_done;

  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  exp_t sb_q[$];
  exp_t sb_e;
  logic started = 1'b0;

  int          m_t;
  logic [15:0] m_active, m_shadow;
  logic        m_pending, m_blz;

  seg_scan_ctrl #(.DIGITS(D), .DIV(V), .BLANK(B)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .blank_lz(blank_lz),
    .number(number), .an(an), .pending(pending), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic exp_t predict(int t, logic [15:0] act, logic blz, logic pend);
    exp_t        e;
    int          slot;
    int          pos;
    logic [15:0] upper;
    logic [3:0]  nb;
    slot  = (t / V) % D;
    pos   = t % V;
    upper = act >> (4 * slot);
    nb    = upper[3:0];
    e.an  = 4'hF;
    if (pos >= B && nb <= 4'd9 && !(blz && slot != 0 && upper == 16'd0)) e.an[slot] = 1'b0;
    e.number     = (nb <= 4'd9) ? nb : 4'd0;
    e.pending    = pend;
    e.frame_done = ((t % F) == F - 1);
    return e;
  endfunction

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h (time %0t)", name, got, want, $time);
    end
  endtask

  // The model advances on the same edges as the DUT and queues what the
  // outputs must look like during the following cycle.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_t       = 0;
      m_active  = '0;
      m_shadow  = '0;
      m_pending = 1'b0;
      m_blz     = 1'b0;
      sb_q.delete();
    end else begin
      if (load && (m_t % F) == F - 1) begin
        m_active  = value;
        m_shadow  = value;
        m_pending = 1'b0;
      end else if (load) begin
        m_shadow  = value;
        m_pending = 1'b1;
      end else if ((m_t % F) == F - 1 && m_pending) begin
        m_active  = m_shadow;
        m_pending = 1'b0;
      end
      m_blz = blank_lz;
      m_t++;
    end
    sb_q.push_back(predict(m_t, m_active, m_blz, m_pending));
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      sb_e = sb_q.pop_front();
      check_output("sb_an", 32'(an), 32'(sb_e.an));
      check_output("sb_number", 32'(number), 32'(sb_e.number));
      check_output("sb_pending", 32'(pending), 32'(sb_e.pending));
      check_output("sb_frame_done", 32'(frame_done), 32'(sb_e.frame_done));
    end else if (started) begin
      check_output("sb_queue_empty", 32'(sb_q.size()), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic goto_cycle(input int c);
    while (cyc < c) step();
  endtask

  task automatic apply_stimulus(input logic [15:0] val);
    load  = 1'b1;
    value = val;
    step();
    load  = 1'b0;
  endtask

  initial begin
    vec_t        vecs[7];
    logic [15:0] nibs;
    logic [3:0]  want_an;
    int          fs;

    vecs[0] = '{16'h1234, 1'b0, 16'h1234, 4'b0000};
    vecs[1] = '{16'h0007, 1'b1, 16'h0007, 4'b1110};
    vecs[2] = '{16'h0007, 1'b0, 16'h0007, 4'b0000};
    vecs[3] = '{16'h0000, 1'b1, 16'h0000, 4'b1110};
    vecs[4] = '{16'h12A4, 1'b0, 16'h1204, 4'b0010};
    vecs[5] = '{16'h0500, 1'b1, 16'h0500, 4'b1000};
    vecs[6] = '{16'h9999, 1'b1, 16'h9999, 4'b0000};

    rst      = 1'b1;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;

    check_output("reset_an", 32'(an), 32'hF);
    check_output("reset_number", 32'(number), 32'h0);
    check_output("reset_pending", 32'(pending), 32'h0);
    check_output("reset_frame_done", 32'(frame_done), 32'h0);
    goto_cycle(1);  check_output("c1_an", 32'(an), 32'hF);
    goto_cycle(2);  check_output("c2_an", 32'(an), 32'hE);
    goto_cycle(5);  apply_stimulus(16'h1234);
    check_output("c6_pending", 32'(pending), 32'h1);
    check_output("c6_an", 32'(an), 32'hE);
    goto_cycle(8);  check_output("c8_an", 32'(an), 32'hF);
    goto_cycle(10); check_output("c10_an", 32'(an), 32'hD);
    goto_cycle(30); check_output("c30_frame_done", 32'(frame_done), 32'h0);
    goto_cycle(31); check_output("c31_frame_done", 32'(frame_done), 32'h1);
    check_output("c31_pending", 32'(pending), 32'h1);
    goto_cycle(32); check_output("c32_pending", 32'(pending), 32'h0);
    nibs = 16'h1234;
    for (int s = 0; s < D; s++) begin
      goto_cycle(32 + 8 * s + 2);
      want_an = 4'hF;
      want_an[s] = 1'b0;
      check_output("basic_number", 32'(number), 32'(nibs[4*s +: 4]));
      check_output("basic_an", 32'(an), 32'(want_an));
    end

    goto_cycle(74); apply_stimulus(16'h0042);
    check_output("race_pending_first", 32'(pending), 32'h1);
    goto_cycle(76); check_output("race_old_value_kept", 32'(number), 32'h3);
    goto_cycle(95); check_output("race_frame_done", 32'(frame_done), 32'h1);
    apply_stimulus(16'h0099);
    check_output("race_pending_clear", 32'(pending), 32'h0);
    nibs = 16'h0099;
    for (int s = 0; s < D; s++) begin
      goto_cycle(96 + 8 * s + 2);
      want_an = 4'hF;
      want_an[s] = 1'b0;
      check_output("race_number", 32'(number), 32'(nibs[4*s +: 4]));
      check_output("race_an", 32'(an), 32'(want_an));
    end

    for (int i = 0; i < 7; i++) begin
      fs = 128 + 64 * i;
      goto_cycle(fs);
      blank_lz = vecs[i].blz;
      goto_cycle(fs + 3);
      apply_stimulus(vecs[i].value);
      for (int s = 0; s < D; s++) begin
        goto_cycle(fs + F + 8 * s);
        check_output("vec_blank_an", 32'(an), 32'hF);
        check_output("vec_blank_number", 32'(number), 32'(vecs[i].exp_num[4*s +: 4]));
        goto_cycle(fs + F + 8 * s + 4);
        want_an = 4'hF;
        if (!vecs[i].exp_dark[s]) want_an[s] = 1'b0;
        check_output("vec_show_number", 32'(number), 32'(vecs[i].exp_num[4*s +: 4]));
        check_output("vec_show_an", 32'(an), 32'(want_an));
      end
    end

    goto_cycle(576);
    blank_lz = 1'b0;
    goto_cycle(581); apply_stimulus(16'h5678);
    check_output("mid_pending_set", 32'(pending), 32'h1);
    goto_cycle(589);
    check_output("mid_an_before_reset", 32'(an), 32'hD);
    #2 rst = 1'b1;
    #1;
    check_output("mid_reset_an", 32'(an), 32'hF);
    check_output("mid_reset_pending", 32'(pending), 32'h0);
    check_output("mid_reset_number", 32'(number), 32'h0);
    step();
    rst = 1'b0;
    cyc = 0;
    check_output("restart_c0_an", 32'(an), 32'hF);
    goto_cycle(2);  check_output("restart_c2_an", 32'(an), 32'hE);
    check_output("restart_c2_number", 32'(number), 32'h0);
    goto_cycle(10); check_output("restart_c10_an", 32'(an), 32'hD);
    goto_cycle(31); check_output("restart_frame_done", 32'(frame_done), 32'h1);
    goto_cycle(33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
